cpu_run_ctrl: RTL

//  Synthesizable, parametrised run controller for the multi-cycle CPU, replacing the fixed reset pulse and fixed cycle budget.
//  It sequences the CPU reset, gates execution with a clock enable, counts executed cycles and stops on done, cycle limit or abort.

---
 rtl/cod_pkg.sv | 17 +
 rtl/cpu_run_ctrl_cycle_counter.sv | 27 ++
 rtl/cpu_run_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/cod_pkg.sv
// Shared types for the CPU run controller: run-state encoding and mode values.
// Used by cpu_run_ctrl and its cycle counter.
package cod_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_PAUSE,
    S_STEP,
    S_FIN
  } run_state_t;

  localparam logic MODE_RUN  = 1'b0;
  localparam logic MODE_STEP = 1'b1;

endpackage

// File: rtl/cpu_run_ctrl_cycle_counter.sv
// Saturating executed-cycle counter with clear and a next-count limit compare.
// LIMIT of zero disables the compare.
module cycle_counter #(
  parameter int CNT_W = 32,
  parameter logic [CNT_W-1:0] LIMIT = '0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             lim_hit
);

  logic [CNT_W:0] cnt_inc;

  assign cnt_inc = {1'b0, cnt} + 1'b1;
  assign lim_hit = (LIMIT != '0) && (cnt_inc == {1'b0, LIMIT});

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt_inc[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the multi-cycle CPU: reset sequencing, enable gating, cycle budget.
// Optional breakpoint support is built when RUN_CTRL_BRK_EN is defined.
module cpu_run_ctrl
  import cod_pkg::*;
#(
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 160,
  parameter int CNT_W      = 32,
  parameter int PC_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic             step,
  input  logic             done_i,
  input  logic [PC_W-1:0]  pc_in,
`ifdef RUN_CTRL_BRK_EN
  input  logic             brk_en,
  input  logic [PC_W-1:0]  brk_pc,
  output logic             brk_hit,
`endif
  output logic             cpu_rst,
  output logic             cpu_en,
  output logic             busy,
  output logic             finished,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [PC_W-1:0]  last_pc
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam logic [RC_W-1:0] RST_LOAD = RC_W'(RST_CYCLES - 1);

  run_state_t      state;
  logic            run_mode;
  logic [RC_W-1:0] rst_cnt;
  logic            cnt_clr;
  logic            lim_hit;
  logic            start_ok;
  logic            brk_now;

  assign start_ok = start && !abort &&
                    ((state == S_IDLE) || (state == S_FIN));
  assign cnt_clr  = rst || start_ok;

`ifdef RUN_CTRL_BRK_EN
  assign brk_now = brk_en && (pc_in == brk_pc);
`else
  assign brk_now = 1'b0;
`endif

  cycle_counter #(
    .CNT_W (CNT_W),
    .LIMIT (CNT_W'(MAX_CYCLES))
  ) u_cnt (
    .clk     (clk),
    .clear   (cnt_clr),
    .en      (cpu_en),
    .cnt     (cycle_cnt),
    .lim_hit (lim_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      run_mode <= MODE_RUN;
      rst_cnt  <= '0;
      cpu_rst  <= 1'b1;
      cpu_en   <= 1'b0;
      busy     <= 1'b0;
      finished <= 1'b0;
      timeout  <= 1'b0;
      last_pc  <= '0;
`ifdef RUN_CTRL_BRK_EN
      brk_hit  <= 1'b0;
`endif
    end else begin
      if (cpu_en) last_pc <= pc_in;
      if (abort) begin
        state   <= S_IDLE;
        cpu_rst <= 1'b1;
        cpu_en  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE, S_FIN: begin
            if (start) begin
              state    <= S_RESET;
              run_mode <= mode;
              rst_cnt  <= RST_LOAD;
              cpu_rst  <= 1'b1;
              busy     <= 1'b1;
              finished <= 1'b0;
              timeout  <= 1'b0;
`ifdef RUN_CTRL_BRK_EN
              brk_hit  <= 1'b0;
`endif
            end
          end
          S_RESET: begin
            if (rst_cnt == '0) begin
              cpu_rst <= 1'b0;
              if (run_mode == MODE_STEP) begin
                state <= S_PAUSE;
              end else begin
                state  <= S_RUN;
                cpu_en <= 1'b1;
              end
            end else begin
              rst_cnt <= rst_cnt - 1'b1;
            end
          end
          S_RUN, S_STEP: begin
            // done beats limit, limit beats breakpoint
            if (done_i) begin
              state    <= S_FIN;
              cpu_en   <= 1'b0;
              busy     <= 1'b0;
              finished <= 1'b1;
            end else if (lim_hit) begin
              state   <= S_FIN;
              cpu_en  <= 1'b0;
              busy    <= 1'b0;
              timeout <= 1'b1;
            end else if (state == S_STEP) begin
              state  <= S_PAUSE;
              cpu_en <= 1'b0;
            end else if (brk_now) begin
              state  <= S_PAUSE;
              cpu_en <= 1'b0;
`ifdef RUN_CTRL_BRK_EN
              brk_hit <= 1'b1;
`endif
            end
          end
          S_PAUSE: begin
            if (done_i) begin
              state    <= S_FIN;
              busy     <= 1'b0;
              finished <= 1'b1;
            end else if (step) begin
              state  <= S_STEP;
              cpu_en <= 1'b1;
`ifdef RUN_CTRL_BRK_EN
              brk_hit <= 1'b0;
`endif
            end
          end
          default: begin
            state   <= S_IDLE;
            cpu_rst <= 1'b1;
            cpu_en  <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
